// File: rtl/sync_data_fifo_if.sv
// Push/pop bundle for sync_data_fifo.
// Ports: push side (iPushData, iPushEnable, oFull, oAlmostFull),
//        pop side (iPopEnable, oPopData, oEmpty), oDataCount,
//        plus oOverflow/oUnderflow when SYNC_DATA_FIFO_ERRFLAG_EN is defined.
//        slave = the FIFO, master = producer/consumer driving it.
interface sync_data_fifo_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 4
);
  logic [DataWidth-1:0]  iPushData;
  logic                  iPushEnable;
  logic                  oFull;
  logic                  oAlmostFull;
  logic                  iPopEnable;
  logic [DataWidth-1:0]  oPopData;
  logic                  oEmpty;
  logic [AddressWidth:0] oDataCount;
`ifdef SYNC_DATA_FIFO_ERRFLAG_EN
  logic                  oOverflow;
  logic                  oUnderflow;

  modport slave (
    input  iPushData, iPushEnable, iPopEnable,
    output oFull, oAlmostFull, oPopData,
    output oEmpty, oDataCount,
    output oOverflow, oUnderflow
  );

  modport master (
    output iPushData, iPushEnable, iPopEnable,
    input  oFull, oAlmostFull, oPopData,
    input  oEmpty, oDataCount,
    input  oOverflow, oUnderflow
  );
`else
  modport slave (
    input  iPushData, iPushEnable, iPopEnable,
    output oFull, oAlmostFull, oPopData,
    output oEmpty, oDataCount
  );

  modport master (
    output iPushData, iPushEnable, iPopEnable,
    input  oFull, oAlmostFull, oPopData,
    input  oEmpty, oDataCount
  );
`endif
endinterface

// File: rtl/sync_data_fifo.sv
// Single-clock FIFO with registered one-cycle read latency.
// Ports: iClock, iReset (sync, active-high), bus (sync_data_fifo_if.slave).
// Full/empty/almost-full decode from an occupancy counter only.
// Optional sticky oOverflow/oUnderflow: define SYNC_DATA_FIFO_ERRFLAG_EN.
module sync_data_fifo #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 4,
  parameter int AlmostFullGap = 2
) (
  input  logic           iClock,
  input  logic           iReset,
  sync_data_fifo_if.slave bus
);

  localparam int Depth = 1 << AddressWidth;

  localparam logic [AddressWidth:0] DepthCount =
    (AddressWidth + 1)'(Depth);

  localparam logic [AddressWidth:0] GapCount =
    (AddressWidth + 1)'(AlmostFullGap);

  logic [DataWidth-1:0]    mem [Depth];
  logic [AddressWidth-1:0] wPtr;
  logic [AddressWidth-1:0] rPtr;
  logic [AddressWidth:0]   count;
  logic [AddressWidth:0]   countNext;
  logic [AddressWidth:0]   freeCount;
  logic [DataWidth-1:0]    popData;

  logic full;
  logic empty;
  logic almostFull;
  logic pushOk;
  logic popOk;

  assign full       = (count == DepthCount);
  assign empty      = (count == '0);
  assign freeCount  = DepthCount - count;
  assign almostFull = (freeCount <= GapCount);

  assign pushOk = bus.iPushEnable && !full;
  assign popOk  = bus.iPopEnable && !empty;

  always_comb begin
    countNext = count;
    unique case (1'b1)
      (pushOk && !popOk): countNext = count + 1'b1;
      (popOk && !pushOk): countNext = count - 1'b1;
      default:            countNext = count;
    endcase
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge iClock) begin
    if (pushOk) begin
      mem[wPtr] <= bus.iPushData;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wPtr    <= '0;
      rPtr    <= '0;
      count   <= '0;
      popData <= '0;
    end else begin
      count <= countNext;
      if (pushOk) begin
        wPtr <= wPtr + 1'b1;
      end
      if (popOk) begin
        rPtr    <= rPtr + 1'b1;
        popData <= mem[rPtr];
      end
    end
  end

  assign bus.oFull       = full;
  assign bus.oEmpty      = empty;
  assign bus.oAlmostFull = almostFull;
  assign bus.oDataCount  = count;
  assign bus.oPopData    = popData;

`ifdef SYNC_DATA_FIFO_ERRFLAG_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.iPushEnable && full) begin
        overflow <= 1'b1;
      end
      if (bus.iPopEnable && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.oOverflow  = overflow;
  assign bus.oUnderflow = underflow;
`endif

endmodule

// File: tb/tb_sync_data_fifo.sv
// Self-checking bench for sync_data_fifo: vector table,
// directed corner sequences and a random stream vs a queue model.
module tb_sync_data_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic iClock = 1'b0;
  logic iReset = 1'b1;

  sync_data_fifo_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

  sync_data_fifo #(
    .DataWidth(DW),
    .AddressWidth(AW),
    .AlmostFullGap(GAP)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus(bus)
  );

  always #5 iClock = ~iClock;

  int compared = 0;
  int mismatched = 0;

  // Reference model: contents as a queue, plus last popped word.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] mLast = '0;
  bit mOvf = 1'b0;
  bit mUnf = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic modelEdge(input bit rst, input bit push,
                           input logic [DW-1:0] d, input bit pop);
    int n;
    n = mq.size();
    if (rst) begin
      mq.delete();
      mLast = '0;
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      if (push && n == DEPTH) mOvf = 1'b1;
      if (pop && n == 0) mUnf = 1'b1;
      if (pop && n > 0) mLast = mq.pop_front();
      if (push && n < DEPTH) mq.push_back(d);
    end
  endtask

  task automatic checkModel();
    int n;
    n = mq.size();
    check("count", 64'(bus.oDataCount), 64'(n));
    check("empty", 64'(bus.oEmpty), 64'(n == 0));
    check("full", 64'(bus.oFull), 64'(n == DEPTH));
    check("almostFull", 64'(bus.oAlmostFull), 64'((DEPTH - n) <= GAP));
    check("popData", 64'(bus.oPopData), 64'(mLast));
`ifdef SYNC_DATA_FIFO_ERRFLAG_EN
    check("overflow", 64'(bus.oOverflow), 64'(mOvf));
    check("underflow", 64'(bus.oUnderflow), 64'(mUnf));
`endif
  endtask

  task automatic step(input bit rst, input bit push,
                      input logic [DW-1:0] d, input bit pop);
    @(negedge iClock);
    iReset          = rst;
    bus.iPushEnable = push;
    bus.iPushData   = d;
    bus.iPopEnable  = pop;
    @(posedge iClock);
    modelEdge(rst, push, d, pop);
    #1;
    checkModel();
  endtask

  typedef struct {
    bit            rst;
    bit            push;
    logic [DW-1:0] data;
    bit            pop;
    int            cnt;
    logic [DW-1:0] pd;
    bit            ovf;
    bit            unf;
  } vec_t;

  vec_t tbl [$];

  function automatic void addVec(bit rst, bit push, logic [DW-1:0] d,
                                 bit pop, int cnt, logic [DW-1:0] pd,
                                 bit ovf, bit unf);
    vec_t v;
    v.rst = rst; v.push = push; v.data = d; v.pop = pop;
    v.cnt = cnt; v.pd = pd; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  logic [DW-1:0] sent [$];
  logic [DW-1:0] recv [$];
  bit ready [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [DW-1:0] saved;
    int peak;
    bit seen55;
    bit doPush;
    bit doPop;
    logic [DW-1:0] w;

    bus.iPushEnable = 1'b0;
    bus.iPopEnable  = 1'b0;
    bus.iPushData   = '0;

    // Fill: reset, 16 pushes, dropped 17th, 16 pops, extra pop.
    addVec(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      addVec(0, 1, DW'(i), 0, i + 1, 0, 0, 0);
    addVec(0, 1, 32'hFF, 0, 16, 0, 1, 0);
    for (int i = 0; i < 16; i++)
      addVec(0, 0, 0, 1, 15 - i, DW'(i), 1, 0);
    addVec(0, 0, 0, 1, 0, 32'h0F, 1, 1);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].push, tbl[k].data, tbl[k].pop);
      check("tblCount", 64'(bus.oDataCount), 64'(tbl[k].cnt));
      check("tblEmpty", 64'(bus.oEmpty), 64'(tbl[k].cnt == 0));
      check("tblFull", 64'(bus.oFull), 64'(tbl[k].cnt == 16));
      check("tblAlmostFull", 64'(bus.oAlmostFull), 64'(tbl[k].cnt >= 14));
      check("tblPopData", 64'(bus.oPopData), 64'(tbl[k].pd));
`ifdef SYNC_DATA_FIFO_ERRFLAG_EN
      check("tblOverflow", 64'(bus.oOverflow), 64'(tbl[k].ovf));
      check("tblUnderflow", 64'(bus.oUnderflow), 64'(tbl[k].unf));
`endif
    end

    // Wrap-around across the pointer boundary.
    for (int i = 0; i < 10; i++) step(0, 1, DW'(32'h100 + i), 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1);
      check("wrapPre", 64'(bus.oPopData), 64'(32'h100 + i));
    end
    peak = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 1, DW'(32'hA0 + i), 0);
      if (int'(bus.oDataCount) > peak) peak = int'(bus.oDataCount);
    end
    check("wrapPeak", 64'(peak), 64'(13));
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 1);
      check("wrapData", 64'(bus.oPopData), 64'(32'hA0 + i));
    end

    // Simultaneous push+pop at count 5.
    for (int i = 0; i < 5; i++) step(0, 1, DW'(32'h200 + i), 0);
    step(0, 1, 32'h205, 1);
    check("simMidCount", 64'(bus.oDataCount), 64'(5));
    check("simMidData", 64'(bus.oPopData), 64'(32'h200));

    // At full: push rejected, pop accepted.
    for (int i = 0; i < 11; i++) step(0, 1, DW'(32'h300 + i), 0);
    check("simFullPre", 64'(bus.oFull), 64'(1));
    step(0, 1, 32'h55, 1);
    check("simFullCount", 64'(bus.oDataCount), 64'(15));
    seen55 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 1);
      if (bus.oPopData == 32'h55) seen55 = 1'b1;
    end
    check("simFullNo55", 64'(seen55), 64'(0));
    check("simFullLast", 64'(bus.oPopData), 64'(32'h30A));

    // At empty: push accepted, pop rejected, no bypass.
    saved = bus.oPopData;
    step(0, 1, 32'h77, 1);
    check("simEmptyCount", 64'(bus.oDataCount), 64'(1));
    check("simEmptyData", 64'(bus.oPopData), 64'(saved));

    // Reset mid-operation wins over a push.
    for (int i = 0; i < 6; i++) step(0, 1, DW'(32'h400 + i), 0);
    check("rstPreCount", 64'(bus.oDataCount), 64'(7));
    step(0, 0, 0, 1);
    step(0, 1, 32'h406, 0);
    step(1, 1, 32'h999, 0);
    check("rstCount", 64'(bus.oDataCount), 64'(0));
    check("rstEmpty", 64'(bus.oEmpty), 64'(1));
    check("rstPopData", 64'(bus.oPopData), 64'(0));

    // Random stream through a ready-gated pop controller.
    for (int c = 0; c < 2000 && recv.size() < 100; c++) begin
      doPush = (sent.size() < 100) && ($urandom_range(0, 3) != 0)
               && !bus.oFull;
      doPop  = ready[c % 5] && !bus.oEmpty;
      w = $urandom;
      step(0, doPush, w, doPop);
      if (doPush) sent.push_back(w);
      if (doPop) recv.push_back(bus.oPopData);
    end
    check("streamCount", 64'(recv.size()), 64'(100));
    if (recv.size() == 100 && sent.size() == 100) begin
      for (int i = 0; i < 100; i++)
        check("streamWord", 64'(recv[i]), 64'(sent[i]));
    end

    @(negedge iClock);
    bus.iPushEnable = 1'b0;
    bus.iPopEnable  = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_data_fifo.md
# sync_data_fifo

Single-clock, first-in first-out data buffer that sits directly upstream of the automatic pop controller in the datapath. It accepts words on a push port and presents them on a pop port with registered, one-cycle read latency. This lets the pop controller assert a pop on a non-empty cycle and raise its valid flag on the next cycle, with the popped word already on the data bus. Occupancy and almost-full status are exported for producer-side throttling.

## Interface
- DataWidth, 32, width of each stored word
- AddressWidth, 4, log2 of depth; depth = 2^AddressWidth (16 by default)
- AlmostFullGap, 2, oAlmostFull asserts when free entries <= AlmostFullGap
- iClock  input  1  clock, all state updates on rising edge
- iReset  input  1  synchronous, active-high reset
- iPushData  input  DataWidth  word to write
- iPushEnable  input  1  write request
- oFull  output  1  count == depth
- oAlmostFull  output  1  (depth - count) <= AlmostFullGap
- iPopEnable  input  1  read request
- oPopData  output  DataWidth  registered read data
- oEmpty  output  1  count == 0
- oDataCount  output  AddressWidth+1  current occupancy, 0..depth

## Operation
- Storage: register array of 2^AddressWidth words; contents are not reset.
- Write pointer and read pointer are AddressWidth bits wide and wrap modulo depth with no special case.
- Count register is AddressWidth+1 bits; the pointers are never compared to detect full or empty.
- Push accepted = iPushEnable && !oFull. On acceptance: mem[wptr] <= iPushData, wptr <= wptr+1.
- Pop accepted = iPopEnable && !oEmpty. On acceptance: oPopData <= mem[rptr], rptr <= rptr+1.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither are accepted.
- Rejected requests (push when full, pop when empty) are silently ignored. Pointers, count, memory and oPopData are unchanged.
- Simultaneous push and pop:
  - When full: pop accepted, push rejected, count goes to depth-1.
  - When empty: push accepted, pop rejected, count goes to 1. There is no write-through bypass.
  - Otherwise: both accepted, count unchanged.
- oPopData holds its last value until the next accepted pop.
- oFull, oEmpty and oAlmostFull are combinational decodes of the count register only. They never depend on the current-cycle iPushEnable or iPopEnable.

## Timing
- Reset values:
  - Pointers 0, count 0.
  - oEmpty=1, oFull=0, oAlmostFull=0 (AlmostFullGap < depth), oDataCount=0, oPopData=0.
- Reset mid-operation discards all buffered words on the next edge. Reset has priority over push and pop in the same cycle.
- Write-to-not-empty latency: a push accepted at edge N gives oEmpty=0 after edge N. A pop may be accepted at edge N+1.
- Read latency: a pop accepted at edge N gives the word on oPopData after edge N. This is valid for the whole cycle that the downstream valid flag is high.
- Flags update one cycle after the accepted event that changes the count.

## Configuration
- Macro SYNC_DATA_FIFO_ERRFLAG_EN.
- When defined, two extra outputs exist:
  - oOverflow (1 bit): sticky, set on any cycle with iPushEnable && oFull.
  - oUnderflow (1 bit): sticky, set on any cycle with iPopEnable && oEmpty.
  - Both are 0 at reset and are cleared only by iReset.
- When undefined, these ports and their logic are absent. Rejected requests are ignored with no indication.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F with pop idle:
  - oEmpty falls after the first push.
  - oAlmostFull rises when oDataCount=14.
  - oFull=1 and oDataCount=16 after the 16th push.
  - A 17th push of 0xFF is dropped, and oOverflow=1 when the macro is defined.
- From full, 16 pops:
  - oPopData sequence is 0x00..0x0F, each word appearing the cycle after its pop.
  - oEmpty=1 after the last pop.
  - A further pop leaves oPopData=0x0F, and oUnderflow=1 when the macro is defined.
- Wrap-around:
  - Push 10, pop 10, then push 0xA0..0xAC (13 words) and pop all.
  - Data order is preserved across the pointer wrap; oDataCount peaks at 13.
- Simultaneous events:
  - At count 5, push+pop together: count stays 5.
  - At full, push 0x55 with pop: count=15 and 0x55 is not stored.
  - At empty, push 0x77 with pop: count=1 and oPopData unchanged.
- Reset mid-operation: with count=7, assert iReset for one cycle together with a push → count=0, oEmpty=1, oPopData=0.
- Streaming with the pop controller attached and iReady toggling 1,0,1,1,0: 100 random words are received in order with no loss or duplication.
